// File: rtl/cv32e40s_pkg.sv
// Shared types for the OBI arbiter slice: requester identifiers.
package cv32e40s_pkg;

  // Requester ID carried through the in-order response FIFO
  typedef enum logic {
    OBI_ARB_ID_INSTR = 1'b0,
    OBI_ARB_ID_DATA  = 1'b1
  } obi_arb_id_e;

  // Round-robin helper: the requester that did not win last time
  function automatic obi_arb_id_e obi_arb_other_id(input obi_arb_id_e id);
    obi_arb_other_id = (id == OBI_ARB_ID_INSTR) ? OBI_ARB_ID_DATA : OBI_ARB_ID_INSTR;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered OBI transfers.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module cv32e40s_obi_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Head is read from the old contents, so a same-cycle push never disturbs the pop
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for storage, wrapping pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cv32e40s_obi_arbiter.sv
// Two-requester OBI arbiter: round-robin address phase with lock-until-grant,
// outstanding limit, and in-order routing of responses back to their owner.
module cv32e40s_obi_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TRANS_W         = 69,
  parameter int unsigned RESP_W          = 33,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req_i,
  input  logic [TRANS_W-1:0] m0_trans_i,
  output logic               m0_gnt_o,
  output logic               m0_rvalid_o,
  input  logic               m1_req_i,
  input  logic [TRANS_W-1:0] m1_trans_i,
  output logic               m1_gnt_o,
  output logic               m1_rvalid_o,
  output logic [RESP_W-1:0]  resp_o,
  output logic               obi_req_o,
  output logic [TRANS_W-1:0] obi_trans_o,
  input  logic               obi_gnt_i,
  input  logic               obi_rvalid_i,
  input  logic [RESP_W-1:0]  obi_resp_i,
  output logic [CNT_W-1:0]   outstanding_o,
  output logic               protocol_err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic        lock_q, lock_d;
  obi_arb_id_e lock_id_q, lock_id_d;
  obi_arb_id_e last_id_q, last_id_d;

  obi_arb_id_e      sel_s;
  logic             has_sel_s;
  logic             sel_req_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [0:0]       head_s;
  logic [CNT_W-1:0] cnt_s;

  // Capacity: a response in the same cycle frees the slot for a new address phase
  assign accept_s = (cnt_s < MAX_CNT) || ((cnt_s == MAX_CNT) && obi_rvalid_i);

  // Pick the requester: the locked one while waiting for grant, else round-robin
  always_comb begin
    sel_s     = OBI_ARB_ID_INSTR;
    has_sel_s = 1'b0;
    if (lock_q) begin
      sel_s     = lock_id_q;
      has_sel_s = 1'b1;
    end else begin
      case ({m1_req_i, m0_req_i})
        2'b01: begin
          sel_s     = OBI_ARB_ID_INSTR;
          has_sel_s = 1'b1;
        end
        2'b10: begin
          sel_s     = OBI_ARB_ID_DATA;
          has_sel_s = 1'b1;
        end
        2'b11: begin
          sel_s     = obi_arb_other_id(last_id_q);
          has_sel_s = 1'b1;
        end
        default: begin
          sel_s     = OBI_ARB_ID_INSTR;
          has_sel_s = 1'b0;
        end
      endcase
    end
  end

  assign sel_req_s   = (sel_s == OBI_ARB_ID_DATA) ? m1_req_i : m0_req_i;
  assign obi_req_o   = has_sel_s && sel_req_s && accept_s;
  assign obi_trans_o = !has_sel_s ? {TRANS_W{1'b0}} :
                       (sel_s == OBI_ARB_ID_DATA) ? m1_trans_i : m0_trans_i;

  assign m0_gnt_o = obi_gnt_i && obi_req_o && (sel_s == OBI_ARB_ID_INSTR);
  assign m1_gnt_o = obi_gnt_i && obi_req_o && (sel_s == OBI_ARB_ID_DATA);

  assign push_s = obi_req_o && obi_gnt_i;
  assign pop_s  = obi_rvalid_i && (cnt_s != {CNT_W{1'b0}});

  assign m0_rvalid_o    = pop_s && (head_s == 1'b0);
  assign m1_rvalid_o    = pop_s && (head_s == 1'b1);
  assign resp_o         = obi_resp_i;
  assign outstanding_o  = cnt_s;
  assign protocol_err_o = obi_rvalid_i && (cnt_s == {CNT_W{1'b0}});

  // Lock holds an ungranted address phase; last winner advances on handshake
  always_comb begin
    lock_d    = obi_req_o && !obi_gnt_i;
    lock_id_d = sel_s;
    if (push_s) begin
      last_id_d = sel_s;
    end else begin
      last_id_d = last_id_q;
    end
  end

  // Arbitration state registers; requester 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= OBI_ARB_ID_INSTR;
      last_id_q <= OBI_ARB_ID_DATA;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_id_q <= last_id_d;
    end
  end

  cv32e40s_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (sel_s),
    .head_o  (head_s),
    .count_o (cnt_s)
  );

endmodule

// File: tb/tb_cv32e40s_obi_arbiter.sv
// Randomized bench with a behavioural model and an owner-ID scoreboard.
module tb_cv32e40s_obi_arbiter;

  localparam int MAXO = 2;
  localparam int TW   = 69;
  localparam int RW   = 33;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req_i, m1_req_i;
  logic [TW-1:0] m0_trans_i, m1_trans_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [RW-1:0] resp_o;
  logic          obi_req_o;
  logic [TW-1:0] obi_trans_o;
  logic          obi_gnt_i, obi_rvalid_i;
  logic [RW-1:0] obi_resp_i;
  logic [CW-1:0] outstanding_o;
  logic          protocol_err_o;

  cv32e40s_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .TRANS_W(TW), .RESP_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_trans_i(m0_trans_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_req_i(m1_req_i), .m1_trans_i(m1_trans_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .resp_o(resp_o), .obi_req_o(obi_req_o), .obi_trans_o(obi_trans_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_resp_i(obi_resp_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding count, last winner, pending (ungranted) owner
  int cnt_m, last_m, locked_m, lid_m;
  int exp_q[$];
  bit rq[2];
  logic [TW-1:0] tr[2];
  int peak_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] rand_trans();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  // Monitor: every response pulse must go to the owner at the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (m0_rvalid_o || m1_rvalid_o)) begin
        chk("rvalid_onehot", {m0_rvalid_o, m1_rvalid_o} == 2'b11, 1'b0);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 1'b1, 1'b0);
        end else begin
          chk("rvalid_owner", m1_rvalid_o ? 1 : 0, exp_q.pop_front());
        end
        chk("resp_data", resp_o, obi_resp_i);
      end
    end
  end

  task automatic model_reset();
    cnt_m    = 0;
    last_m   = 1;
    locked_m = 0;
    lid_m    = 0;
    exp_q.delete();
  endtask

  // One bus cycle: drive, check against the model at mid-cycle, advance the model
  task automatic cycle(input bit fg, input bit g, input bit fr, input bit r);
    int  winner;
    bit  accept, exp_req, hs, pop;
    logic [63:0] rr;
    @(posedge clk);
    #1;
    m0_req_i     = rq[0];
    m1_req_i     = rq[1];
    m0_trans_i   = tr[0];
    m1_trans_i   = tr[1];
    obi_gnt_i    = fg ? g : 1'($urandom_range(0, 1));
    if (fr) obi_rvalid_i = r;
    else if (cnt_m > 0) obi_rvalid_i = ($urandom_range(0, 9) < 4);
    else obi_rvalid_i = ($urandom_range(0, 19) == 0);
    rr = {$urandom(), $urandom()};
    obi_resp_i = rr[RW-1:0];
    @(negedge clk);
    #1;
    accept = (cnt_m < MAXO) || (cnt_m == MAXO && obi_rvalid_i);
    if (locked_m) winner = lid_m;
    else if (rq[0] && rq[1]) winner = 1 - last_m;
    else if (rq[0]) winner = 0;
    else if (rq[1]) winner = 1;
    else winner = -1;
    exp_req = (winner >= 0) && rq[winner] && accept;
    hs  = exp_req && obi_gnt_i;
    pop = obi_rvalid_i && (cnt_m > 0);
    chk("obi_req", obi_req_o, exp_req);
    chk("obi_trans", obi_trans_o, (winner >= 0) ? tr[winner] : '0);
    chk("m0_gnt", m0_gnt_o, hs && winner == 0);
    chk("m1_gnt", m1_gnt_o, hs && winner == 1);
    chk("outstanding", outstanding_o, cnt_m);
    chk("protocol_err", protocol_err_o, obi_rvalid_i && cnt_m == 0);
    chk("rvalid_any", m0_rvalid_o || m1_rvalid_o, pop);
    if (hs) begin
      last_m = winner;
      exp_q.push_back(winner);
      cnt_m++;
    end
    if (pop) cnt_m--;
    if (cnt_m > peak_m) peak_m = cnt_m;
    locked_m = exp_req && !obi_gnt_i;
    if (winner >= 0) lid_m = winner;
    // Requesters hold req and payload until granted, then pick something new
    for (int i = 0; i < 2; i++) begin
      if (!rq[i] || (hs && winner == i)) begin
        rq[i] = 1'($urandom_range(0, 1));
        tr[i] = rand_trans();
      end
    end
  endtask

  initial begin
    bit reached;
    peak_m       = 0;
    rst_n        = 1'b0;
    m0_req_i     = 1'b0;
    m1_req_i     = 1'b0;
    m0_trans_i   = '0;
    m1_trans_i   = '0;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_resp_i   = '0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    tr[0] = '0;   tr[1] = '0;
    model_reset();
    #12;
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_obi_req", obi_req_o, 1'b0);
    chk("reset_err", protocol_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious response with nothing outstanding, then quiet cycle
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);

    // Both request with constant grant: alternation and in-order routing
    rq[0] = 1'b1; rq[1] = 1'b1; tr[0] = rand_trans(); tr[1] = rand_trans();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, (i >= 2));

    // Randomized traffic: capacity stalls, locks, mixed orderings, spurious rvalids
    for (int i = 0; i < 3000; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("peak_reached_max", peak_m, MAXO);

    // Fill to MAX outstanding, then reset mid-transfer
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cnt_m == MAXO) begin
        reached = 1'b1;
        break;
      end
      rq[0] = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("fill_to_max", reached, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outstanding", outstanding_o, 0);
    model_reset();
    rq[0] = 1'b0; rq[1] = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    obi_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Late response for a pre-reset transfer is a protocol error
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40s_obi_arbiter.md
Name: cv32e40s_obi_arbiter

Overview:
- Shares one OBI master port between two requesters: requester 0 (instruction fetch) and requester 1 (load/store).
- Arbitrates address phases round-robin and holds the choice stable while a request waits for grant.
- Records the requester ID of every accepted transfer in an in-order ID FIFO and routes each rvalid/response back to the owning requester.
- Limits outstanding transfers to MAX_OUTSTANDING, flags responses arriving with nothing outstanding, and sits between the core's bus interfaces and the OBI integrity checking on the shared port.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transfers on the shared port (1..4).
- TRANS_W, 69: width of the packed address-phase payload (addr, we, be, wdata).
- RESP_W, 33: width of the packed response payload (rdata, err).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i  in  1  requester 0 address-phase request
- m0_trans_i  in  TRANS_W  requester 0 payload
- m0_gnt_o  out  1  requester 0 grant
- m0_rvalid_o  out  1  requester 0 response valid
- m1_req_i  in  1  requester 1 address-phase request
- m1_trans_i  in  TRANS_W  requester 1 payload
- m1_gnt_o  out  1  requester 1 grant
- m1_rvalid_o  out  1  requester 1 response valid
- resp_o  out  RESP_W  response payload, fanned out to both requesters
- obi_req_o  out  1  shared port request
- obi_trans_o  out  TRANS_W  shared port payload
- obi_gnt_i  in  1  shared port grant
- obi_rvalid_i  in  1  shared port response valid
- obi_resp_i  in  RESP_W  shared port response
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
- protocol_err_o  out  1  rvalid received with zero outstanding

Behaviour:
- State registers and reset values:
  - cnt_q = 0
  - lock_q = 0 (a request was issued last cycle and not granted)
  - lock_id_q = 0
  - last_id_q = 1 (requester 0 wins the first contention)
  - ID FIFO: all entries 0, wr_ptr = rd_ptr = 0
- Capacity: accept = cnt_q < MAX_OUTSTANDING, OR (cnt_q == MAX_OUTSTANDING AND obi_rvalid_i). A same-cycle response frees the slot.
- Selection when lock_q = 0:
  - Only one requester active: select it.
  - Both active: select !last_id_q.
  - Neither active: no request.
- Selection when lock_q = 1: select lock_id_q regardless of the other requester. This keeps OBI address-phase stability; the locked requester must keep req high, which is the requester's obligation.
- Shared port drive (combinational, zero latency):
  - obi_req_o = selected requester's req AND accept.
  - obi_trans_o = selected requester's payload, or 0 when there is no selection.
- Grant routing: mX_gnt_o = obi_gnt_i AND obi_req_o AND (sel == X). The unselected requester's gnt is 0.
- Lock update each cycle:
  - lock_q <= obi_req_o AND !obi_gnt_i
  - lock_id_q <= sel
  - When capacity blocks the request, obi_req_o is 0, so no lock is taken.
- On handshake (obi_req_o AND obi_gnt_i):
  - last_id_q <= sel
  - Push sel into the ID FIFO; wr_ptr wraps modulo MAX_OUTSTANDING.
- Response (obi_rvalid_i AND cnt_q != 0):
  - Pop the head ID and pulse m[head]_rvalid_o in the same cycle.
  - rd_ptr wraps modulo MAX_OUTSTANDING.
- resp_o = obi_resp_i unconditionally; requesters qualify it with their own rvalid.
- Counter next value, from push and pop:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
  - cnt_q never exceeds MAX_OUTSTANDING and never underflows.
- Push and pop in the same cycle at full or at count 1: the FIFO stays consistent because the pop reads the old head before the write lands.
- Spurious response (obi_rvalid_i AND cnt_q == 0):
  - protocol_err_o = 1, combinational, same cycle.
  - No mX_rvalid_o asserted; no state change.
- outstanding_o = cnt_q.
- Reset asserted mid-transfer: all state clears asynchronously. Responses later arriving for pre-reset transfers raise protocol_err_o.

Decomposition:
- In cv32e40s_pkg: a typedef for the 1-bit requester ID (OBI_ARB_ID_INSTR = 0, OBI_ARB_ID_DATA = 1).
- One sub-module, cv32e40s_obi_arb_id_fifo:
  - Parameters: DEPTH = MAX_OUTSTANDING, WIDTH = 1.
  - Ports: push, pop, data in, head out, count.
  - Reused later for wider requester IDs.

Test Plan:
- Arbitration and routing: m0 and m1 both request, gnt_i = 1 every cycle, rvalid 2 cycles later → grants go m0, m1, m0; each rvalid reaches the matching mX_rvalid_o in order; outstanding_o peaks at 2.
- Capacity stall: MAX_OUTSTANDING = 2, two granted transfers, no rvalid → third request sees obi_req_o = 0; when rvalid_i = 1 in the same cycle as the stalled request, obi_req_o = 1 and cnt stays 2.
- Lock: m0 requests with gnt_i = 0 for 3 cycles, m1 rises in cycle 2 → obi_trans_o holds m0's payload, m1_gnt_o = 0; after m0 is granted, m1 is selected next.
- Mixed ordering: grant m1 then m0, return two rvalids → first response to m1_rvalid_o, second to m0_rvalid_o.
- Spurious rvalid at cnt = 0 → protocol_err_o = 1 for that cycle only, m0/m1_rvalid_o = 0, outstanding_o stays 0.
- Reset with 2 outstanding → outstanding_o = 0 immediately; the next rvalid raises protocol_err_o.
